counter_sweep_ctrl: RTL and testbench

COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

---
 rtl/counter_sweep_if.sv | 45 ++++
 rtl/counter_sweep_ctrl.sv | 138 +++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_sweep_if.sv
//------------------------------------------------------------------------------
// counter_sweep_if : control/status bundle between the sweep controller and
// its counter. cnt_err exists only when COUNT_CHECK_EN is defined.
// Revision 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface counter_sweep_if #(parameter int WIDTH = 4);
  logic             start;
  logic             abort;
  logic             hold;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [3:0]       passes;
  logic [WIDTH-1:0] count;
  logic             en;
  logic             dn;
  logic             load;
  logic [WIDTH-1:0] data;
  logic             busy;
  logic             done;
  logic             cfg_err;
`ifdef COUNT_CHECK_EN
  logic             cnt_err;
`endif

  modport master (
    input  start, abort, hold, lo, hi, passes, count,
    output en, dn, load, data, busy, done, cfg_err
`ifdef COUNT_CHECK_EN
    , output cnt_err
`endif
  );

  modport slave (
    output start, abort, hold, lo, hi, passes, count,
    input  en, dn, load, data, busy, done, cfg_err
`ifdef COUNT_CHECK_EN
    , input cnt_err
`endif
  );
endinterface

`default_nettype wire

// File: rtl/counter_sweep_ctrl.sv
//------------------------------------------------------------------------------
// counter_sweep_ctrl : drives an up/down counter through lo..hi..lo triangles.
// Optional COUNT_CHECK_EN adds a shadow count model and sticky cnt_err.
// Revision 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module counter_sweep_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  counter_sweep_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [3:0]       pass_q, pass_d;
  logic             cfg_err_q, cfg_err_d;
  logic             cfg_ok;
  logic             ctl_en, ctl_dn, ctl_load, is_busy;

  assign cfg_ok = (bus.lo < bus.hi) && (bus.passes != 4'd0);

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    pass_d    = pass_q;
    cfg_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (cfg_ok) begin
            lo_d    = bus.lo;
            hi_d    = bus.hi;
            pass_d  = bus.passes;
            state_d = S_LOAD;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_LOAD: state_d = S_UP;
      S_UP: begin
        if (!bus.hold && (bus.count == hi_q - C_ONE)) state_d = S_DOWN;
      end
      S_DOWN: begin
        if (!bus.hold && (bus.count == lo_q + C_ONE)) begin
          pass_d  = pass_q - 4'd1;
          state_d = (pass_q == 4'd1) ? S_DONE : S_UP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort overrides hold and the bound checks above
    if (bus.abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      pass_q    <= 4'd0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      pass_q    <= pass_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // hold gates en combinationally so releasing it loses no cycle
  assign ctl_load = (state_q == S_LOAD);
  assign ctl_dn   = (state_q == S_DOWN);
  assign ctl_en   = ctl_load || (((state_q == S_UP) || (state_q == S_DOWN)) && !bus.hold);
  assign is_busy  = (state_q != S_IDLE);

  assign bus.en      = ctl_en;
  assign bus.dn      = ctl_dn;
  assign bus.load    = ctl_load;
  assign bus.data    = lo_q;
  assign bus.busy    = is_busy;
  assign bus.done    = (state_q == S_DONE);
  assign bus.cfg_err = cfg_err_q;

`ifdef COUNT_CHECK_EN
  logic [WIDTH-1:0] pred_q, pred_d;
  logic             chk_q, chk_d;
  logic             cnt_err_q, cnt_err_d;

  always_comb begin
    pred_d    = bus.count;
    chk_d     = is_busy;
    cnt_err_d = cnt_err_q;
    if (ctl_load)    pred_d = lo_q;
    else if (ctl_en) pred_d = ctl_dn ? (bus.count - C_ONE) : (bus.count + C_ONE);
    if ((state_q == S_IDLE) && bus.start && cfg_ok) begin
      cnt_err_d = 1'b0;
    end else if (chk_q && is_busy && (bus.count != pred_q)) begin
      cnt_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_q    <= '0;
      chk_q     <= 1'b0;
      cnt_err_q <= 1'b0;
    end else begin
      pred_q    <= pred_d;
      chk_q     <= chk_d;
      cnt_err_q <= cnt_err_d;
    end
  end

  assign bus.cnt_err = cnt_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_counter_sweep_ctrl.sv
//------------------------------------------------------------------------------
// tb_counter_sweep_ctrl : directed bench for counter_sweep_ctrl with a local
// up/down counter closing the loop. Revision 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cnt_q;
  logic [3:0] inj;
  int         n_assert = 0;
  int         n_fail   = 0;
  int         busy_cycles;
  int         done_cnt;
  logic       found;

  logic [3:0] exp_a [7] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2};
  logic [3:0] exp_d [6] = '{4'd7, 4'd8, 4'd9, 4'd8, 4'd7, 4'd6};

  counter_sweep_if #(.WIDTH(4)) bus ();

  counter_sweep_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt_q <= 4'd0;
    else if (bus.load) cnt_q <= bus.data;
    else if (bus.en)   cnt_q <= bus.dn ? (cnt_q - 4'd1) : (cnt_q + 4'd1);
  end

  assign bus.count = cnt_q + inj;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [3:0] l, input logic [3:0] h, input logic [3:0] p);
    bus.lo     = l;
    bus.hi     = h;
    bus.passes = p;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    logic got;
    got = 1'b0;
    for (int k = 0; k < max_cyc && !got; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) got = 1'b1;
    end
    chk(tag, got, 1);
  endtask

  function automatic logic [3:0] tri_exp(input int i);
    int j;
    j = i % 30;
    if (i >= 60) return 4'd0;
    return (j < 15) ? 4'(j) : 4'(30 - j);
  endfunction

  initial begin
    rst_n = 1'b0; inj = 4'd0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.hold = 1'b0;
    bus.lo = 4'd0; bus.hi = 4'd0; bus.passes = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_en", bus.en, 0);
    chk("rst_dn", bus.dn, 0);
    chk("rst_load", bus.load, 0);
    chk("rst_data", bus.data, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cfg_err", bus.cfg_err, 0);
`ifdef COUNT_CHECK_EN
    chk("rst_cnt_err", bus.cnt_err, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // single pass 2..5..2, with new start/bounds presented while busy
    go(4'd2, 4'd5, 4'd1);
    chk("a_load", bus.load, 1);
    chk("a_load_en", bus.en, 1);
    chk("a_load_dn", bus.dn, 0);
    chk("a_data", bus.data, 2);
    busy_cycles = bus.busy ? 1 : 0;
    bus.start = 1'b1; bus.lo = 4'd0; bus.hi = 4'd9; bus.passes = 4'd3;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 2) bus.start = 1'b0;
      if (bus.busy) busy_cycles++;
      chk("a_count", bus.count, exp_a[i]);
      chk("a_done", bus.done, (i == 6) ? 1 : 0);
      chk("a_data_kept", bus.data, 2);
    end
    @(negedge clk);
    chk("a_idle_busy", bus.busy, 0);
    chk("a_idle_done", bus.done, 0);
    chk("a_busy_span", busy_cycles, 8);
`ifdef COUNT_CHECK_EN
    chk("a_cnt_err", bus.cnt_err, 0);
`endif

    // two full 0..15..0 triangles
    go(4'd0, 4'd15, 4'd2);
    chk("b_load", bus.load, 1);
    done_cnt = 0;
    for (int i = 0; i <= 60; i++) begin
      @(negedge clk);
      chk("b_count", bus.count, tri_exp(i));
      if (bus.done) done_cnt++;
    end
    repeat (2) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    chk("b_done_once", done_cnt, 1);
    chk("b_idle", bus.busy, 0);

    // illegal configurations
    go(4'd7, 4'd7, 4'd1);
    chk("c_cfg_err", bus.cfg_err, 1);
    chk("c_busy", bus.busy, 0);
    chk("c_load", bus.load, 0);
    @(negedge clk);
    chk("c_cfg_err_pulse", bus.cfg_err, 0);
    chk("c_busy2", bus.busy, 0);
    go(4'd1, 4'd3, 4'd0);
    chk("c_pass0_err", bus.cfg_err, 1);
    chk("c_pass0_busy", bus.busy, 0);
    @(negedge clk);
    chk("c_pass0_pulse", bus.cfg_err, 0);

    // hold mid-UP at 4, then abort at 6 in DOWN
    go(4'd1, 4'd9, 4'd1);
    chk("d_load", bus.load, 1);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (bus.count == 4'd4) found = 1'b1;
    end
    chk("d_reach4", found, 1);
    bus.hold = 1'b1;
    #1 chk("d_hold_en", bus.en, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("d_hold_count", bus.count, 4);
      chk("d_hold_busy", bus.busy, 1);
    end
    bus.hold = 1'b0;
    @(negedge clk);
    chk("d_resume5", bus.count, 5);
    @(negedge clk);
    chk("d_resume6", bus.count, 6);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("d_count", bus.count, exp_d[k]);
    end
    chk("e_in_down", bus.dn, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("e_busy", bus.busy, 0);
    chk("e_en", bus.en, 0);
    chk("e_done", bus.done, 0);
    @(negedge clk);
    chk("e_done2", bus.done, 0);

    // hi-lo == 1: one up step and one down step
    go(4'd3, 4'd4, 4'd1);
    chk("e_load", bus.load, 1);
    chk("e_data", bus.data, 3);
    @(negedge clk);
    chk("f_up3", bus.count, 3);
    chk("f_up_dn", bus.dn, 0);
    @(negedge clk);
    chk("f_dn4", bus.count, 4);
    chk("f_dn_dn", bus.dn, 1);
    @(negedge clk);
    chk("f_end3", bus.count, 3);
    chk("f_done", bus.done, 1);
    chk("f_done_en", bus.en, 0);
    @(negedge clk);
    chk("f_idle", bus.busy, 0);

    // reset mid-sweep, then restart
    go(4'd2, 4'd5, 4'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("r_busy", bus.busy, 0);
    chk("r_en", bus.en, 0);
    chk("r_data", bus.data, 0);
    chk("r_load", bus.load, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    go(4'd2, 4'd5, 4'd1);
    chk("r_load2", bus.load, 1);
    chk("r_data2", bus.data, 2);
    wait_done("r_done", 12);
    @(negedge clk);

`ifdef COUNT_CHECK_EN
    // count disturbed by one for a single cycle
    go(4'd0, 4'd9, 4'd1);
    repeat (3) @(negedge clk);
    chk("g_count2", bus.count, 2);
    chk("g_clean", bus.cnt_err, 0);
    inj = 4'd1;
    @(negedge clk);
    inj = 4'd0;
    chk("g_err_set", bus.cnt_err, 1);
    wait_done("g_done", 30);
    @(negedge clk);
    chk("g_err_sticky", bus.cnt_err, 1);
    go(4'd2, 4'd5, 4'd1);
    chk("g_err_clear", bus.cnt_err, 0);
    wait_done("g_done2", 12);
    chk("g_err_clean2", bus.cnt_err, 0);
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
